// File: rtl/video_shifter_pkg.sv
// Shared types and defaults for the character-cell pixel serializer.
package video_shifter_pkg;

    localparam int unsigned PIXELS_PER_CHAR_DEFAULT = 8;
    localparam int unsigned GLYPH_W = 8;

    typedef logic [GLYPH_W-1:0] glyph_t;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StShift
    } shifter_state_e;

endpackage

// File: rtl/video_shifter_if.sv
// Handshake bundle between video timing / glyph fetch path (master) and the shifter (slave).
interface video_shifter_if;

    logic                      pixel_en_i;
    logic                      display_en_i;
    logic                      fetch_req_o;
    video_shifter_pkg::glyph_t glyph_i;
    logic                      reverse_i;
    logic                      glyph_valid_i;
    logic                      underrun_clr_i;
    logic                      video_o;
    logic                      underrun_o;

    modport master (
        output pixel_en_i,
        output display_en_i,
        output glyph_i,
        output reverse_i,
        output glyph_valid_i,
        output underrun_clr_i,
        input  fetch_req_o,
        input  video_o,
        input  underrun_o
    );

    modport slave (
        input  pixel_en_i,
        input  display_en_i,
        input  glyph_i,
        input  reverse_i,
        input  glyph_valid_i,
        input  underrun_clr_i,
        output fetch_req_o,
        output video_o,
        output underrun_o
    );

endinterface

// File: rtl/video_shifter.sv
// Pixel serializer: requests one glyph per character cell inside the display window and
// shifts it out MSB-first on each pixel strobe, flagging cells loaded without their glyph.
module video_shifter
    import video_shifter_pkg::*;
#(
    parameter int unsigned PIXELS_PER_CHAR = PIXELS_PER_CHAR_DEFAULT,
    parameter int unsigned PREFETCH_AT     = 3,
    parameter bit          INVERT_OUTPUT   = 1'b0
) (
    input logic            clk16_i,
    input logic            reset_i,
    video_shifter_if.slave bus
);

    localparam int unsigned CntW = (PIXELS_PER_CHAR > 1) ? $clog2(PIXELS_PER_CHAR) : 1;
    localparam logic [CntW-1:0] LastBit  = CntW'(PIXELS_PER_CHAR - 1);
    localparam logic [CntW-1:0] FetchBit = CntW'(PREFETCH_AT);
    localparam logic            Blank    = INVERT_OUTPUT;

    shifter_state_e  state_q;
    logic [CntW-1:0] bit_cnt_q;
    glyph_t          shreg_q;
    glyph_t          hold_q;
    logic            pending_q;
    logic            hold_valid_q;
    logic            video_q;
    logic            fetch_q;
    logic            underrun_q;

    glyph_t glyph_in;
    glyph_t load_value;
    logic   capture;
    logic   drop;
    logic   at_last;
    logic   do_load;
    logic   do_fetch;
    logic   load_empty;

    always_comb begin
        glyph_in   = bus.glyph_i ^ {GLYPH_W{bus.reverse_i}};
        capture    = bus.glyph_valid_i && pending_q;
        drop       = bus.pixel_en_i && !bus.display_en_i;
        at_last    = (bit_cnt_q == LastBit);
        do_load    = bus.pixel_en_i && bus.display_en_i && (state_q != StIdle) && at_last;
        do_fetch   = bus.pixel_en_i && bus.display_en_i &&
                     ((state_q == StIdle) || ((state_q == StShift) && (bit_cnt_q == FetchBit)));
        load_empty = do_load && !capture && !hold_valid_q;
        // A strobe landing exactly on the load slot goes straight into the shifter.
        if (capture) begin
            load_value = glyph_in;
        end else if (hold_valid_q) begin
            load_value = hold_q;
        end else begin
            load_value = '0;
        end
    end

    always_ff @(posedge clk16_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            hold_q       <= '0;
            pending_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            video_q      <= 1'b0;
            fetch_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            fetch_q <= do_fetch;

            if (load_empty) begin
                underrun_q <= 1'b1;
            end else if (bus.underrun_clr_i) begin
                underrun_q <= 1'b0;
            end

            if (drop) begin
                pending_q    <= 1'b0;
                hold_valid_q <= 1'b0;
            end else begin
                if (do_fetch) begin
                    pending_q <= 1'b1;
                end else if (capture) begin
                    pending_q <= 1'b0;
                end
                if (do_load) begin
                    hold_valid_q <= 1'b0;
                end else if (capture) begin
                    hold_q       <= glyph_in;
                    hold_valid_q <= 1'b1;
                end
            end

            if (drop) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                shreg_q   <= '0;
                video_q   <= Blank;
            end else if (bus.pixel_en_i) begin
                unique case (state_q)
                    StIdle: begin
                        video_q   <= Blank;
                        bit_cnt_q <= '0;
                        state_q   <= StPrime;
                    end
                    StPrime: begin
                        video_q   <= Blank;
                        bit_cnt_q <= at_last ? '0 : bit_cnt_q + CntW'(1);
                        if (at_last) begin
                            state_q <= StShift;
                        end
                    end
                    StShift: begin
                        video_q   <= shreg_q[GLYPH_W-1] ^ INVERT_OUTPUT;
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= at_last ? '0 : bit_cnt_q + CntW'(1);
                    end
                    default: state_q <= StIdle;
                endcase
                if (do_load) begin
                    shreg_q <= load_value;
                end
            end
        end
    end

    assign bus.fetch_req_o = fetch_q;
    assign bus.video_o     = video_q;
    assign bus.underrun_o  = underrun_q;

endmodule
